pulse_gen: RTL and testbench

Synthetic alpha/gamma pulse generator; the transmit-side counterpart of the alpha/gamma event counter. Software loads event descriptors over the system bus into a FIFO: inter-event gap `t0`, width `t1`, peak amplitude and type. The block replays them as rectangular pulses on the two 14-bit DAC outputs. Looping `dat_a_o`/`dat_b_o` back into the counter's ADC inputs lets the counter be exercised with known events.

---
 rtl/pulse_gen.sv | 184 ++++++++++++++++++
 tb/tb_pulse_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen.sv
// Synthetic alpha/gamma pulse generator: replays bus-loaded event descriptors
// as rectangular pulses on two 14-bit DAC channels over baseline levels.
module pulse_gen #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  output logic [13:0] dat_a_o,
  output logic [13:0] dat_b_o,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);

  localparam logic [19:0] A_AMP    = 20'h00;
  localparam logic [19:0] A_T0     = 20'h04;
  localparam logic [19:0] A_T1     = 20'h08;
  localparam logic [19:0] A_CTRL   = 20'h0C;
  localparam logic [19:0] A_BASE   = 20'h10;
  localparam logic [19:0] A_LVL    = 20'h14;
  localparam logic [19:0] A_PULSES = 20'h18;
  localparam logic [19:0] A_DROPS  = 20'h1C;

  typedef struct packed {
    logic [31:0] t0;
    logic [15:0] t1;
    logic [13:0] amp;
    logic        typ;
  } desc_t;

  typedef enum logic [1:0] {IDLE, GAP, PULSE} state_t;

  state_t      state;
  logic [13:0] st_amp, cur_amp, base_a, base_b;
  logic        st_typ, cur_typ, en;
  logic [31:0] st_t0, gcnt, pulses, drops;
  logic [15:0] st_t1, wcnt, max_lvl;
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0] rd_mux;
  logic [19:0] a;
  logic        flush, commit, full, push, pop;
  desc_t       mem [FIFO_DEPTH];
  desc_t       head;
  logic        unused_bits;

  assign unused_bits = ^{sys_sel, sys_addr[31:20]};
  assign sys_err = 1'b0;

  assign a      = sys_addr[19:0];
  assign flush  = sys_wen && (a == A_CTRL) && sys_wdata[1];
  assign commit = sys_wen && (a == A_T1) && !flush;
  assign full   = (cnt == FULL_LVL);
  assign push   = commit && !full;
  assign pop    = (state == IDLE) && en && (cnt != '0) && !flush;
  assign head   = mem[rp];

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)
      cnt_nxt = cnt + 1'b1;
    else if (pop && !push)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wp] <= '{t0: st_t0, t1: sys_wdata[15:0], amp: st_amp, typ: st_typ};
  end

  always_comb begin
    rd_mux = '0;
    case (a)
      A_AMP:    rd_mux = {17'b0, st_typ, st_amp};
      A_T0:     rd_mux = st_t0;
      A_T1:     rd_mux = {16'b0, st_t1};
      A_CTRL:   rd_mux = {31'b0, en};
      A_BASE:   rd_mux = {2'b0, base_b, 2'b0, base_a};
      A_LVL:    rd_mux = {max_lvl, 16'(cnt)};
      A_PULSES: rd_mux = pulses;
      A_DROPS:  rd_mux = drops;
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      st_amp    <= '0;
      st_typ    <= 1'b0;
      st_t0     <= '0;
      st_t1     <= '0;
      en        <= 1'b0;
      base_a    <= '0;
      base_b    <= '0;
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      max_lvl   <= '0;
      drops     <= '0;
      pulses    <= '0;
      state     <= IDLE;
      gcnt      <= '0;
      wcnt      <= '0;
      cur_amp   <= '0;
      cur_typ   <= 1'b0;
      dat_a_o   <= '0;
      dat_b_o   <= '0;
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      if (sys_wen) begin
        case (a)
          A_AMP:  begin st_amp <= sys_wdata[13:0]; st_typ <= sys_wdata[14]; end
          A_T0:   st_t0 <= sys_wdata;
          A_T1:   st_t1 <= sys_wdata[15:0];
          A_CTRL: en <= sys_wdata[0];
          A_BASE: begin base_a <= sys_wdata[13:0]; base_b <= sys_wdata[29:16]; end
          default: ;
        endcase
      end

      if (flush) begin
        wp      <= '0;
        rp      <= '0;
        cnt     <= '0;
        max_lvl <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
        cnt <= cnt_nxt;
        if (16'(cnt_nxt) > max_lvl) max_lvl <= 16'(cnt_nxt);
        if (commit && full) drops <= drops + 1'b1;
      end

      // The width counter is loaded at pop and left untouched through GAP.
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (pop) begin
            cur_amp <= head.amp;
            cur_typ <= head.typ;
            wcnt    <= head.t1;
            if (head.t0 == '0) begin
              state <= PULSE;
            end else begin
              gcnt  <= head.t0;
              state <= GAP;
            end
          end
          GAP: begin
            if (gcnt == 32'd1) state <= PULSE;
            else               gcnt  <= gcnt - 1'b1;
          end
          PULSE: begin
            if (wcnt == '0) begin
              state  <= IDLE;
              pulses <= pulses + 1'b1;
            end else begin
              wcnt <= wcnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      dat_a_o <= (!flush && state == PULSE && !cur_typ) ? cur_amp : base_a;
      dat_b_o <= (!flush && state == PULSE &&  cur_typ) ? cur_amp : base_b;

      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= sys_ren ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: pulse timing, gamma pulses, FIFO full/drop,
// flush, enable cleared mid-event and asynchronous reset mid-pulse.
module tb_pulse_gen;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [13:0] dat_a_o, dat_b_o;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic [3:0]  sys_sel;
  logic        sys_wen, sys_ren, sys_err, sys_ack;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [13:0] GAM_AMP = 14'h3830;  // -2000 in 14-bit two's complement

  always #5 clk_i = ~clk_i;

  pulse_gen #(.FIFO_DEPTH(16)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .dat_a_o   (dat_a_o),
    .dat_b_o   (dat_b_o),
    .sys_addr  (sys_addr),
    .sys_wdata (sys_wdata),
    .sys_sel   (sys_sel),
    .sys_wen   (sys_wen),
    .sys_ren   (sys_ren),
    .sys_rdata (sys_rdata),
    .sys_err   (sys_err),
    .sys_ack   (sys_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk_i);
    sys_addr  = addr;
    sys_wdata = data;
    sys_wen   = 1'b1;
    @(negedge clk_i);
    sys_wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic ack);
    @(negedge clk_i);
    sys_addr = addr;
    sys_ren  = 1'b1;
    @(posedge clk_i);
    #1 ack = sys_ack;
    @(negedge clk_i);
    sys_ren = 1'b0;
    data = sys_rdata;
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        k;
    bus_read(addr, d, k);
    check(tag, d, exp);
  endtask

  task automatic commit(input logic [31:0] t0, input logic [15:0] t1,
                        input logic [13:0] amp, input logic typ);
    bus_write(32'h00, {17'b0, typ, amp});
    bus_write(32'h04, t0);
    bus_write(32'h08, {16'b0, t1});
  endtask

  initial begin
    logic [31:0] d;
    logic        k;
    int          hits;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [13:0] seq_b [6];

    rstn_i = 1'b0;
    sys_addr = '0; sys_wdata = '0; sys_sel = 4'hF; sys_wen = 1'b0; sys_ren = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_dat_a", 32'(dat_a_o), 32'd0);
    check("rst_dat_b", 32'(dat_b_o), 32'd0);
    check("rst_ack",   32'(sys_ack), 32'd0);
    check("rst_err",   32'(sys_err), 32'd0);
    check("rst_rdata", sys_rdata,    32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;

    bus_read(32'h14, d, k);
    check("rst_level", d, 32'd0);
    check("read_ack", 32'(k), 32'd1);
    read_check("rst_pulses", 32'h18, 32'd0);

    // Alpha pulse t0=3 t1=4 amp=1000
    commit(32'd3, 16'd4, 14'd1000, 1'b0);
    read_check("stage_t0",  32'h04, 32'd3);
    read_check("stage_t1",  32'h08, 32'd4);
    read_check("stage_amp", 32'h00, 32'd1000);
    read_check("lvl_one",   32'h14, 32'h0001_0001);
    read_check("unmapped",  32'h20, 32'd0);
    bus_write(32'h0C, 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i);
      #1;
      exp_a = (i >= 4 && i <= 8) ? 32'd1000 : 32'd0;
      check($sformatf("alpha_a[%0d]", i), 32'(dat_a_o), exp_a);
      check($sformatf("alpha_b[%0d]", i), 32'(dat_b_o), 32'd0);
    end
    read_check("alpha_pulses", 32'h18, 32'd1);

    // Two gamma pulses t0=0 t1=0 amp=-2000 baseline chB=50
    bus_write(32'h0C, 32'd0);
    bus_write(32'h10, 32'h0032_0000);
    commit(32'd0, 16'd0, GAM_AMP, 1'b1);
    commit(32'd0, 16'd0, GAM_AMP, 1'b1);
    read_check("gam_level", 32'h14, 32'h0002_0002);
    bus_write(32'h0C, 32'd1);
    seq_b = '{14'd50, GAM_AMP, 14'd50, GAM_AMP, 14'd50, 14'd50};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i);
      #1;
      exp_b = 32'(seq_b[i]);
      check($sformatf("gam_b[%0d]", i), 32'(dat_b_o), exp_b);
      check($sformatf("gam_a[%0d]", i), 32'(dat_a_o), 32'd0);
    end
    read_check("gam_pulses", 32'h18, 32'd3);

    // FIFO full: 18 commits into depth 16
    bus_write(32'h0C, 32'd0);
    for (int i = 0; i < 18; i++) commit(32'd0, 16'd0, 14'd7, 1'b0);
    read_check("full_level", 32'h14, 32'h0010_0010);
    read_check("full_drops", 32'h1C, 32'd2);
    bus_write(32'h0C, 32'd1);
    hits = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_i);
      #1 if (dat_a_o == 14'd7) hits++;
    end
    check("full_pulse_cycles", 32'(hits), 32'd16);
    read_check("full_pulses", 32'h18, 32'd19);
    read_check("full_drained", 32'h14, 32'h0010_0000);

    // Flush mid-pulse with 5 queued
    bus_write(32'h0C, 32'd0);
    bus_write(32'h10, 32'h0032_000B);
    for (int i = 0; i < 6; i++) commit(32'd2, 16'd20, 14'd300, 1'b0);
    bus_write(32'h0C, 32'd1);
    repeat (10) @(posedge clk_i);
    #1 check("flush_pre", 32'(dat_a_o), 32'd300);
    bus_write(32'h0C, 32'd3);
    check("flush_a", 32'(dat_a_o), 32'd11);
    check("flush_b", 32'(dat_b_o), 32'd50);
    read_check("flush_level", 32'h14, 32'd0);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      #1 if (dat_a_o == 14'd300) hits++;
    end
    check("flush_no_pulse", 32'(hits), 32'd0);
    read_check("flush_pulses", 32'h18, 32'd19);
    read_check("flush_ctrl",   32'h0C, 32'd1);
    read_check("flush_drops",  32'h1C, 32'd2);

    // Enable cleared during GAP
    bus_write(32'h0C, 32'd0);
    commit(32'd6, 16'd2, 14'd500, 1'b1);
    commit(32'd6, 16'd2, 14'd500, 1'b1);
    bus_write(32'h0C, 32'd1);
    bus_write(32'h0C, 32'd0);
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i);
      #1 if (dat_b_o == 14'd500) hits++;
    end
    check("gapdis_width", 32'(hits), 32'd3);
    read_check("gapdis_level",  32'h14, 32'h0002_0001);
    read_check("gapdis_pulses", 32'h18, 32'd20);
    bus_write(32'h0C, 32'd1);
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i);
      #1 if (dat_b_o == 14'd500) hits++;
    end
    check("reen_width", 32'(hits), 32'd3);
    read_check("reen_pulses", 32'h18, 32'd21);
    read_check("reen_level",  32'h14, 32'h0002_0000);

    // Asynchronous reset mid-pulse
    bus_write(32'h0C, 32'd0);
    commit(32'd0, 16'd30, 14'd777, 1'b0);
    bus_write(32'h0C, 32'd1);
    repeat (5) @(posedge clk_i);
    #1 check("rstmid_pre", 32'(dat_a_o), 32'd777);
    #2 rstn_i = 1'b0;
    #1;
    check("rstmid_a", 32'(dat_a_o), 32'd0);
    check("rstmid_b", 32'(dat_b_o), 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    read_check("rstmid_level",  32'h14, 32'd0);
    read_check("rstmid_pulses", 32'h18, 32'd0);
    read_check("rstmid_base",   32'h10, 32'd0);
    read_check("rstmid_drops",  32'h1C, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
